// File: rtl/systolic_ctrl_if.sv
// Scheduler/array-facing signal bundle for the systolic tile sequencer.
// master = tile scheduler side, slave = sequencer side.
interface systolic_ctrl_if #(
  parameter int N   = 4,
  parameter int K_W = 8
);
  logic           start;
  logic [K_W-1:0] k_len;
  logic           busy;
  logic           done;
  logic           arr_rst_n;
  logic           rd_en;
  logic [K_W-1:0] rd_addr;
  logic [N-1:0]   row_valid;
  logic [N-1:0]   col_valid;

  modport master (
    output start, k_len,
    input  busy, done, arr_rst_n, rd_en, rd_addr, row_valid, col_valid
  );

  modport slave (
    input  start, k_len,
    output busy, done, arr_rst_n, rd_en, rd_addr, row_valid, col_valid
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN MAC array: clears accumulators, streams k_len operand
// reads, emits row/column skewed valids, waits out the pipeline, pulses done.
module systolic_ctrl #(
  parameter int N       = 4,
  parameter int K_W     = 8,
  parameter int HOP_LAT = 3,
  parameter int MAC_LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  systolic_ctrl_if.slave bus
);
  localparam int DRAIN_CYC = N + 2*(N-1)*HOP_LAT + MAC_LAT;
  localparam int D_W       = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [K_W-1:0] r_k_reg;
  logic [K_W-1:0] r_k_cnt;
  logic [D_W-1:0] r_d_cnt;
  logic [N-1:0]   r_skew;
  logic           w_last_k;
  logic           w_last_d;
  logic           w_feed;

  assign w_feed   = (r_state == S_FEED);
  assign w_last_k = (r_k_cnt == (r_k_reg - K_W'(1)));
  assign w_last_d = (r_d_cnt == D_W'(DRAIN_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CLEAR;
      S_CLEAR: w_next = (r_k_reg == '0) ? S_DONE : S_FEED;
      S_FEED:  if (w_last_k) w_next = S_DRAIN;
      S_DRAIN: if (w_last_d) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // k_len is only sampled on acceptance; later changes on the bus are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k_reg <= '0;
      r_k_cnt <= '0;
      r_d_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) r_k_reg <= bus.k_len;
        S_CLEAR: r_k_cnt <= '0;
        S_FEED: begin
          r_k_cnt <= r_k_cnt + K_W'(1);
          r_d_cnt <= '0;
        end
        S_DRAIN: r_d_cnt <= r_d_cnt + D_W'(1);
        default: ;
      endcase
    end
  end

  // Lane 0 lines up with the 1-cycle buffer read; lane i lags lane 0 by i.
  // The chain runs in every state so trailing strobes empty out during DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skew <= '0;
    end else begin
      r_skew[0] <= w_feed;
      for (int i = 1; i < N; i++) r_skew[i] <= r_skew[i-1];
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.arr_rst_n = reset & (r_state != S_CLEAR);
  assign bus.rd_en     = w_feed;
  assign bus.rd_addr   = w_feed ? r_k_cnt : '0;
  assign bus.row_valid = r_skew;
  assign bus.col_valid = r_skew;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: cycle traces against a timing model
// plus a scoreboard of expected accumulator tiles checked at each done.
module tb_systolic_ctrl;
  localparam int N         = 4;
  localparam int K_W       = 8;
  localparam int HOP_LAT   = 3;
  localparam int MAC_LAT   = 3;
  localparam int DRAIN_CYC = N + 2*(N-1)*HOP_LAT + MAC_LAT;
  localparam int VW        = 4 + K_W + 2*N;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  systolic_ctrl_if #(.N(N), .K_W(K_W)) bus ();

  systolic_ctrl #(.N(N), .K_W(K_W), .HOP_LAT(HOP_LAT), .MAC_LAT(MAC_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Operand buffers and a behavioural array: each row/column lane records the
  // k index it was strobed with; cell (i,j) pairs the t-th a with the t-th b.
  int A [N][256];
  int B [256][N];
  int kpipe [N];
  int rowk [N][256];
  int colk [N][256];
  int rcnt [N];
  int ccnt [N];
  int rd_cnt   = 0;
  int done_cnt = 0;
  int sb_k [$];
  int sb_acc [$];

  initial begin
    for (int i = 0; i < N; i++) begin kpipe[i] = 0; rcnt[i] = 0; ccnt[i] = 0; end
    forever begin
      @(posedge clk);
      if (!reset || !bus.arr_rst_n) begin
        for (int i = 0; i < N; i++) begin rcnt[i] = 0; ccnt[i] = 0; end
        rd_cnt = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (bus.row_valid[i] && rcnt[i] < 256) begin rowk[i][rcnt[i]] = kpipe[i]; rcnt[i]++; end
          if (bus.col_valid[i] && ccnt[i] < 256) begin colk[i][ccnt[i]] = kpipe[i]; ccnt[i]++; end
        end
        if (bus.rd_en) rd_cnt++;
        if (bus.done) begin
          done_cnt++;
          n_checks++;
          if (sb_k.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected_done got done with empty scoreboard at %0t", $time);
          end else begin
            int k;
            int bad;
            k = sb_k.pop_front();
            if (rd_cnt !== k) begin
              n_errors++;
              $display("FAIL sb_rd_count got %0d exp %0d", rd_cnt, k);
            end
            n_checks++;
            bad = 0;
            for (int i = 0; i < N; i++) begin
              if (rcnt[i] !== k || ccnt[i] !== k) bad++;
              for (int j = 0; j < N; j++) begin
                int e;
                int got;
                e   = sb_acc.pop_front();
                got = 0;
                for (int t = 0; t < rcnt[i] && t < ccnt[j]; t++)
                  got += A[i][rowk[i][t]] * B[colk[j][t]][j];
                if (got !== e) begin
                  bad++;
                  $display("FAIL sb_acc cell(%0d,%0d) got %0d exp %0d", i, j, got, e);
                end
              end
            end
            if (bad != 0) n_errors++;
          end
        end
      end
      for (int i = N-1; i > 0; i--) kpipe[i] = kpipe[i-1];
      kpipe[0] = int'(bus.rd_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs c cycles after the cycle in which start is presented.
  function automatic logic [VW-1:0] exp_vec(int c, int k);
    int             dc;
    logic           rd;
    logic [K_W-1:0] addr;
    logic [N-1:0]   rv;
    dc   = (k == 0) ? 2 : k + 2 + DRAIN_CYC;
    rd   = (k > 0) && (c >= 2) && (c <= k + 1);
    addr = rd ? K_W'(c - 2) : '0;
    for (int i = 0; i < N; i++) rv[i] = (k > 0) && (c >= 3 + i) && (c <= k + 2 + i);
    return {(c != 1), rd, addr, rv, rv, (c == dc), (c >= 1) && (c <= dc)};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus.arr_rst_n, bus.rd_en, bus.rd_addr, bus.row_valid, bus.col_valid, bus.done, bus.busy};
  endfunction

  task automatic fill(int mode);
    for (int i = 0; i < N; i++)
      for (int t = 0; t < 256; t++) begin
        case (mode)
          0:       begin A[i][t] = (i == t) ? 1 : 0; B[t][i] = (i == t) ? 1 : 0; end
          1:       begin A[i][t] = 2; B[t][i] = 3; end
          default: begin A[i][t] = int'($urandom_range(0, 15)); B[t][i] = int'($urandom_range(0, 15)); end
        endcase
      end
  endtask

  task automatic push_exp(int k);
    sb_k.push_back(k);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int t = 0; t < k; t++) s += A[i][t] * B[t][j];
        sb_acc.push_back(s);
      end
  endtask

  task automatic test_reset();
    logic [VW-1:0] e;
    reset = 1'b0; bus.start = 1'b0; bus.k_len = '0;
    repeat (3) tick();
    e = '0;
    n_checks++;
    if (act_vec() !== e) begin n_errors++; $display("FAIL reset_outputs got %h exp %h", act_vec(), e); end
    reset = 1'b1;
    tick();
    e = exp_vec(0, 0);
    n_checks++;
    if (act_vec() !== e) begin n_errors++; $display("FAIL reset_release got %h exp %h", act_vec(), e); end
  endtask

  // One tile; poke re-pulses start at relative cycles 5 and 20, k_len churns while busy.
  task automatic run_tile(string name, int k, bit poke);
    int dc;
    int d0;
    dc = (k == 0) ? 2 : k + 2 + DRAIN_CYC;
    d0 = done_cnt;
    push_exp(k);
    bus.start = 1'b1;
    bus.k_len = K_W'(k);
    for (int c = 0; c <= dc + 2; c++) begin
      logic [VW-1:0] e;
      logic [VW-1:0] a;
      e = exp_vec(c, k);
      a = act_vec();
      n_checks++;
      if (a !== e) begin n_errors++; $display("FAIL %s cyc%0d got %h exp %h", name, c, a, e); end
      tick();
      bus.start = poke && ((c + 1 == 5) || (c + 1 == 20));
      bus.k_len = K_W'($urandom);
    end
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_errors++; $display("FAIL %s done_pulses got %0d exp 1", name, done_cnt - d0); end
    n_checks++;
    if (sb_k.size() !== 0) begin n_errors++; $display("FAIL %s sb_left got %0d exp 0", name, sb_k.size()); end
  endtask

  task automatic test_back_to_back();
    int per;
    int d0;
    per = 2 + 2 + DRAIN_CYC + 1;
    d0  = done_cnt;
    fill(2);
    push_exp(2);
    push_exp(2);
    bus.start = 1'b1;
    bus.k_len = K_W'(2);
    for (int c = 0; c < 2 * per; c++) begin
      logic [VW-1:0] e;
      e = exp_vec(c % per, 2);
      n_checks++;
      if (act_vec() !== e) begin n_errors++; $display("FAIL b2b cyc%0d got %h exp %h", c, act_vec(), e); end
      tick();
    end
    bus.start = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL b2b_idle busy got %b exp 0", bus.busy); end
    n_checks++;
    if (done_cnt - d0 !== 2) begin n_errors++; $display("FAIL b2b_done_pulses got %0d exp 2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int            guard;
    int            d0;
    logic [VW-1:0] e;
    fill(2);
    push_exp(8);
    bus.start = 1'b1;
    bus.k_len = K_W'(8);
    tick();
    bus.start = 1'b0;
    guard = 0;
    while (!(bus.rd_en === 1'b1 && bus.rd_addr === K_W'(4)) && guard < 50) begin tick(); guard++; end
    n_checks++;
    if (guard >= 50) begin n_errors++; $display("FAIL mid_reset_wait got timeout exp rd_addr 4"); end
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    e = '0;
    n_checks++;
    if (act_vec() !== e) begin n_errors++; $display("FAIL mid_reset_async got %h exp %h", act_vec(), e); end
    sb_k.delete();
    sb_acc.delete();
    repeat (3) tick();
    n_checks++;
    if (act_vec() !== e) begin n_errors++; $display("FAIL mid_reset_hold got %h exp %h", act_vec(), e); end
    reset = 1'b1;
    repeat (40) tick();
    n_checks++;
    if (done_cnt !== d0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_no_done got done+%0d busy %b exp done+0 busy 0", done_cnt - d0, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    fill(2); run_tile("basic_k3", 3, 1'b0);
    fill(2); run_tile("k_zero", 0, 1'b0);
    fill(0); run_tile("identity_k4", 4, 1'b0);
    fill(1); run_tile("twos_threes_k4", 4, 1'b0);
    fill(2); run_tile("ignore_start", 3, 1'b1);
    fill(2); run_tile("k_max", 255, 1'b0);
    test_back_to_back();
    test_reset_mid();
    fill(0); run_tile("after_reset", 5, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
